// File: rtl/branch_issue_queue_pkg.sv
// Shared widths, the queue entry layout, the ex-stage bundle
// and the operand wakeup helper for the branch issue queue.
package branch_issue_queue_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int PHY_W  = 6;
  localparam int ROB_W  = 5;

  typedef struct packed {
    logic              valid;
    logic [ADDR_W-1:0] addr;
    logic [6:0]        opcode;
    logic [2:0]        funct3;
    logic [11:0]       imm;
    logic [PHY_W-1:0]  rs1_tag;
    logic              rs1_rdy;
    logic [DATA_W-1:0] rs1_data;
    logic [PHY_W-1:0]  rs2_tag;
    logic              rs2_rdy;
    logic [DATA_W-1:0] rs2_data;
    logic [ROB_W-1:0]  rob_id;
    logic              pred_taken;
    logic [ADDR_W-1:0] pred_target;
  } branch_rs_entry_t;

  typedef struct packed {
    logic              valid;
    logic [ADDR_W-1:0] addr;
    logic [6:0]        opcode;
    logic [2:0]        funct3;
    logic [11:0]       imm;
    logic [DATA_W-1:0] rs1_data;
    logic [DATA_W-1:0] rs2_data;
    logic [ROB_W-1:0]  rob_id;
    logic              pred_taken;
    logic [ADDR_W-1:0] pred_target;
  } branch_ex_t;

  // Already-ready sources are left alone so a stale tag match cannot clobber data.
  function automatic branch_rs_entry_t rs_wake(
    input branch_rs_entry_t  e,
    input logic              v,
    input logic [PHY_W-1:0]  t,
    input logic [DATA_W-1:0] d
  );
    branch_rs_entry_t r;
    r = e;
    if (v && !e.rs1_rdy && e.rs1_tag == t) begin
      r.rs1_rdy  = 1'b1;
      r.rs1_data = d;
    end
    if (v && !e.rs2_rdy && e.rs2_tag == t) begin
      r.rs2_rdy  = 1'b1;
      r.rs2_data = d;
    end
    return r;
  endfunction

endpackage

// File: rtl/branch_issue_queue_select.sv
// Find-first-set over the entry ready vector.
// Lowest index wins, which is the oldest entry in the compacting queue.
module branch_rs_select #(
  parameter int DEPTH = 4,
  parameter int IW    = $clog2(DEPTH)
) (
  input  logic [DEPTH-1:0] req,
  output logic             found,
  output logic [IW-1:0]    idx
);

  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (req[i]) begin
        found = 1'b1;
        idx   = IW'(i);
      end
    end
  end

endmodule

// File: rtl/branch_issue_queue.sv
// Branch reservation station: compacting queue, oldest-ready select,
// ex register feeding the branch unit, registered resolution to the ROB.
module branch_issue_queue
  import branch_issue_queue_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_W,
  parameter int DATA_WIDTH = DATA_W,
  parameter int DEPTH      = 4,
  parameter int PHY_WIDTH  = PHY_W,
  parameter int ROB_WIDTH  = ROB_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  dispatch_valid,
  output logic                  dispatch_ready,
  input  logic [ADDR_WIDTH-1:0] dispatch_addr,
  input  logic [6:0]            dispatch_opcode,
  input  logic [2:0]            dispatch_funct3,
  input  logic [11:0]           dispatch_imm,
  input  logic [PHY_WIDTH-1:0]  dispatch_rs1_tag,
  input  logic                  dispatch_rs1_rdy,
  input  logic [DATA_WIDTH-1:0] dispatch_rs1_data,
  input  logic [PHY_WIDTH-1:0]  dispatch_rs2_tag,
  input  logic                  dispatch_rs2_rdy,
  input  logic [DATA_WIDTH-1:0] dispatch_rs2_data,
  input  logic [ROB_WIDTH-1:0]  dispatch_rob_id,
  input  logic                  dispatch_pred_taken,
  input  logic [ADDR_WIDTH-1:0] dispatch_pred_target,
  input  logic                  cdb_valid,
  input  logic [PHY_WIDTH-1:0]  cdb_tag,
  input  logic [DATA_WIDTH-1:0] cdb_data,
  output logic [ADDR_WIDTH-1:0] bu_instruction_addr,
  output logic [DATA_WIDTH-1:0] bu_rs1_data,
  output logic [DATA_WIDTH-1:0] bu_rs2_data,
  output logic [6:0]            bu_opcode,
  output logic [11:0]           bu_immediate,
  output logic [2:0]            bu_funct3,
  input  logic [ADDR_WIDTH-1:0] bu_jump_address,
  input  logic                  bu_isJump,
  output logic                  resolve_valid,
  output logic [ROB_WIDTH-1:0]  resolve_rob_id,
  output logic                  resolve_mispredict,
  output logic [ADDR_WIDTH-1:0] resolve_target,
  output logic [ADDR_WIDTH-1:0] resolve_link
);

  localparam int IW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  branch_rs_entry_t ent_q [DEPTH];
  branch_rs_entry_t ent_d [DEPTH];
  branch_rs_entry_t woke  [DEPTH];
  branch_rs_entry_t new_ent;
  branch_ex_t       ex_q, ex_d;

  logic [CW-1:0]         count_q, count_d, cnt_left;
  logic [DEPTH-1:0]      rdy_vec;
  logic                  found, issue, accept;
  logic [IW-1:0]         sel_idx;
  logic                  res_valid_q, res_valid_d;
  logic [ROB_WIDTH-1:0]  res_rob_q, res_rob_d;
  logic                  res_mis_q, res_mis_d;
  logic [ADDR_WIDTH-1:0] res_tgt_q, res_tgt_d;
  logic [ADDR_WIDTH-1:0] res_link_q, res_link_d;
  logic [ADDR_WIDTH-1:0] ex_link;

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      rdy_vec[i] = ent_q[i].valid & ent_q[i].rs1_rdy & ent_q[i].rs2_rdy;
    end
  end

  branch_rs_select #(
    .DEPTH (DEPTH),
    .IW    (IW)
  ) u_select (
    .req   (rdy_vec),
    .found (found),
    .idx   (sel_idx)
  );

  assign dispatch_ready = (count_q < CW'(DEPTH));
  assign accept         = dispatch_valid & dispatch_ready & ~flush;
  assign issue          = found & ~flush;
  assign cnt_left       = count_q - CW'(issue);

  // x0 reads as zero and never waits; the CDB can bypass into the new entry.
  always_comb begin
    new_ent             = '0;
    new_ent.valid       = 1'b1;
    new_ent.addr        = dispatch_addr;
    new_ent.opcode      = dispatch_opcode;
    new_ent.funct3      = dispatch_funct3;
    new_ent.imm         = dispatch_imm;
    new_ent.rs1_tag     = dispatch_rs1_tag;
    new_ent.rs1_rdy     = dispatch_rs1_rdy | (dispatch_rs1_tag == '0);
    new_ent.rs1_data    = dispatch_rs1_rdy ? dispatch_rs1_data : '0;
    new_ent.rs2_tag     = dispatch_rs2_tag;
    new_ent.rs2_rdy     = dispatch_rs2_rdy | (dispatch_rs2_tag == '0);
    new_ent.rs2_data    = dispatch_rs2_rdy ? dispatch_rs2_data : '0;
    new_ent.rob_id      = dispatch_rob_id;
    new_ent.pred_taken  = dispatch_pred_taken;
    new_ent.pred_target = dispatch_pred_target;
    new_ent = rs_wake(new_ent, cdb_valid, cdb_tag, cdb_data);
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      woke[i]  = rs_wake(ent_q[i], cdb_valid, cdb_tag, cdb_data);
      ent_d[i] = woke[i];
    end
    for (int i = 0; i < DEPTH - 1; i++) begin
      if (issue && i >= int'(sel_idx)) ent_d[i] = woke[i+1];
    end
    if (issue) ent_d[DEPTH-1] = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (accept && cnt_left == CW'(i)) ent_d[i] = new_ent;
    end
    count_d = cnt_left + CW'(accept);
    if (flush) begin
      for (int i = 0; i < DEPTH; i++) ent_d[i] = '0;
      count_d = '0;
    end
  end

  always_comb begin
    ex_d = '0;
    if (issue) begin
      ex_d.valid       = 1'b1;
      ex_d.addr        = ent_q[sel_idx].addr;
      ex_d.opcode      = ent_q[sel_idx].opcode;
      ex_d.funct3      = ent_q[sel_idx].funct3;
      ex_d.imm         = ent_q[sel_idx].imm;
      ex_d.rs1_data    = ent_q[sel_idx].rs1_data;
      ex_d.rs2_data    = ent_q[sel_idx].rs2_data;
      ex_d.rob_id      = ent_q[sel_idx].rob_id;
      ex_d.pred_taken  = ent_q[sel_idx].pred_taken;
      ex_d.pred_target = ent_q[sel_idx].pred_target;
    end
  end

  assign ex_link = ex_q.addr + ADDR_WIDTH'(4);

  always_comb begin
    res_valid_d = ex_q.valid & ~flush;
    res_rob_d   = '0;
    res_mis_d   = 1'b0;
    res_tgt_d   = '0;
    res_link_d  = '0;
    if (res_valid_d) begin
      res_rob_d  = ex_q.rob_id;
      res_mis_d  = (bu_isJump != ex_q.pred_taken) |
                   (bu_isJump & (bu_jump_address != ex_q.pred_target));
      res_tgt_d  = bu_isJump ? bu_jump_address : ex_link;
      res_link_d = ex_link;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
      count_q     <= '0;
      ex_q        <= '0;
      res_valid_q <= 1'b0;
      res_rob_q   <= '0;
      res_mis_q   <= 1'b0;
      res_tgt_q   <= '0;
      res_link_q  <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= ent_d[i];
      count_q     <= count_d;
      ex_q        <= ex_d;
      res_valid_q <= res_valid_d;
      res_rob_q   <= res_rob_d;
      res_mis_q   <= res_mis_d;
      res_tgt_q   <= res_tgt_d;
      res_link_q  <= res_link_d;
    end
  end

  assign bu_instruction_addr = ex_q.addr;
  assign bu_rs1_data         = ex_q.rs1_data;
  assign bu_rs2_data         = ex_q.rs2_data;
  assign bu_opcode           = ex_q.opcode;
  assign bu_immediate        = ex_q.imm;
  assign bu_funct3           = ex_q.funct3;

  assign resolve_valid      = res_valid_q;
  assign resolve_rob_id     = res_rob_q;
  assign resolve_mispredict = res_mis_q;
  assign resolve_target     = res_tgt_q;
  assign resolve_link       = res_link_q;

endmodule

// File: tb/tb_branch_issue_queue.sv
// Directed and random checks of branch_issue_queue against a
// queue-based reference model and a behavioural branch unit.
module tb_branch_issue_queue;

  localparam logic [6:0] OP_BR   = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam int QD = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush;
  logic        dispatch_valid, dispatch_ready;
  logic [31:0] dispatch_addr;
  logic [6:0]  dispatch_opcode;
  logic [2:0]  dispatch_funct3;
  logic [11:0] dispatch_imm;
  logic [5:0]  dispatch_rs1_tag, dispatch_rs2_tag;
  logic        dispatch_rs1_rdy, dispatch_rs2_rdy;
  logic [31:0] dispatch_rs1_data, dispatch_rs2_data;
  logic [4:0]  dispatch_rob_id;
  logic        dispatch_pred_taken;
  logic [31:0] dispatch_pred_target;
  logic        cdb_valid;
  logic [5:0]  cdb_tag;
  logic [31:0] cdb_data;
  logic [31:0] bu_instruction_addr, bu_rs1_data, bu_rs2_data;
  logic [6:0]  bu_opcode;
  logic [11:0] bu_immediate;
  logic [2:0]  bu_funct3;
  logic [31:0] bu_jump_address;
  logic        bu_isJump;
  logic        resolve_valid, resolve_mispredict;
  logic [4:0]  resolve_rob_id;
  logic [31:0] resolve_target, resolve_link;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  branch_issue_queue dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .flush                (flush),
    .dispatch_valid       (dispatch_valid),
    .dispatch_ready       (dispatch_ready),
    .dispatch_addr        (dispatch_addr),
    .dispatch_opcode      (dispatch_opcode),
    .dispatch_funct3      (dispatch_funct3),
    .dispatch_imm         (dispatch_imm),
    .dispatch_rs1_tag     (dispatch_rs1_tag),
    .dispatch_rs1_rdy     (dispatch_rs1_rdy),
    .dispatch_rs1_data    (dispatch_rs1_data),
    .dispatch_rs2_tag     (dispatch_rs2_tag),
    .dispatch_rs2_rdy     (dispatch_rs2_rdy),
    .dispatch_rs2_data    (dispatch_rs2_data),
    .dispatch_rob_id      (dispatch_rob_id),
    .dispatch_pred_taken  (dispatch_pred_taken),
    .dispatch_pred_target (dispatch_pred_target),
    .cdb_valid            (cdb_valid),
    .cdb_tag              (cdb_tag),
    .cdb_data             (cdb_data),
    .bu_instruction_addr  (bu_instruction_addr),
    .bu_rs1_data          (bu_rs1_data),
    .bu_rs2_data          (bu_rs2_data),
    .bu_opcode            (bu_opcode),
    .bu_immediate         (bu_immediate),
    .bu_funct3            (bu_funct3),
    .bu_jump_address      (bu_jump_address),
    .bu_isJump            (bu_isJump),
    .resolve_valid        (resolve_valid),
    .resolve_rob_id       (resolve_rob_id),
    .resolve_mispredict   (resolve_mispredict),
    .resolve_target       (resolve_target),
    .resolve_link         (resolve_link)
  );

  function automatic logic f_taken(input logic [6:0] op, input logic [2:0] f3,
                                   input logic [31:0] a, input logic [31:0] b);
    if (op != OP_BR) return 1'b1;
    case (f3)
      3'd0: return a == b;
      3'd1: return a != b;
      3'd4: return $signed(a) < $signed(b);
      3'd5: return $signed(a) >= $signed(b);
      3'd6: return a < b;
      3'd7: return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] f_tgt(input logic [6:0] op, input logic [31:0] addr,
                                        input logic [11:0] imm, input logic [31:0] a);
    logic [31:0] s;
    s = {{20{imm[11]}}, imm};
    if (op == OP_JALR) return (a + s) & ~32'd1;
    return addr + s;
  endfunction

  always_comb begin
    bu_isJump       = f_taken(bu_opcode, bu_funct3, bu_rs1_data, bu_rs2_data);
    bu_jump_address = f_tgt(bu_opcode, bu_instruction_addr, bu_immediate, bu_rs1_data);
  end

  typedef struct {
    logic [31:0] addr;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [11:0] imm;
    logic [5:0]  t1, t2;
    logic        r1, r2;
    logic [31:0] d1, d2;
    logic [4:0]  rob;
    logic        pt;
    logic [31:0] ptgt;
  } op_t;

  op_t         mq[$];
  op_t         mex;
  bit          mex_v = 0;
  bit          mres_v = 0;
  logic [4:0]  mres_rob = '0;
  bit          mres_mis = 0;
  logic [31:0] mres_tgt = '0;
  logic [31:0] mres_link = '0;

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    checks++;
    assert (o === e) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  task automatic idle();
    dispatch_valid = 0;
    cdb_valid      = 0;
    cdb_tag        = '0;
    cdb_data       = '0;
    flush          = 0;
  endtask

  task automatic disp(input logic [31:0] a, input logic [6:0] op, input logic [2:0] f3,
                      input logic [11:0] imm, input logic [5:0] t1, input logic r1,
                      input logic [31:0] d1, input logic [5:0] t2, input logic r2,
                      input logic [31:0] d2, input logic [4:0] rob, input logic pt,
                      input logic [31:0] ptgt);
    dispatch_valid       = 1;
    dispatch_addr        = a;
    dispatch_opcode      = op;
    dispatch_funct3      = f3;
    dispatch_imm         = imm;
    dispatch_rs1_tag     = t1;
    dispatch_rs1_rdy     = r1;
    dispatch_rs1_data    = d1;
    dispatch_rs2_tag     = t2;
    dispatch_rs2_rdy     = r2;
    dispatch_rs2_data    = d2;
    dispatch_rob_id      = rob;
    dispatch_pred_taken  = pt;
    dispatch_pred_target = ptgt;
  endtask

  task automatic cdb(input logic [5:0] t, input logic [31:0] d);
    cdb_valid = 1;
    cdb_tag   = t;
    cdb_data  = d;
  endtask

  // One clock: check the visible state, advance the model, then check resolution.
  task automatic tick();
    op_t         n, nex;
    bit          nexv, nres_v, acc, tk;
    int          sel;
    logic [31:0] tg;
    chk("dispatch_ready", dispatch_ready, mq.size() < QD);
    chk("bu_addr", bu_instruction_addr, mex_v ? mex.addr : 32'd0);
    chk("bu_rs1", bu_rs1_data, mex_v ? mex.d1 : 32'd0);
    chk("bu_rs2", bu_rs2_data, mex_v ? mex.d2 : 32'd0);
    acc = dispatch_valid && (mq.size() < QD) && !flush;
    sel = -1;
    foreach (mq[i]) if (sel < 0 && mq[i].r1 && mq[i].r2) sel = i;
    nres_v = mex_v && !flush;
    tk = f_taken(mex.op, mex.f3, mex.d1, mex.d2);
    tg = f_tgt(mex.op, mex.addr, mex.imm, mex.d1);
    nexv = (sel >= 0) && !flush;
    nex = mex;
    if (sel >= 0) nex = mq[sel];
    foreach (mq[i]) begin
      if (cdb_valid && !mq[i].r1 && mq[i].t1 == cdb_tag) begin
        mq[i].r1 = 1; mq[i].d1 = cdb_data;
      end
      if (cdb_valid && !mq[i].r2 && mq[i].t2 == cdb_tag) begin
        mq[i].r2 = 1; mq[i].d2 = cdb_data;
      end
    end
    if (sel >= 0 && !flush) mq.delete(sel);
    if (acc) begin
      n.addr = dispatch_addr; n.op = dispatch_opcode; n.f3 = dispatch_funct3;
      n.imm = dispatch_imm; n.t1 = dispatch_rs1_tag; n.t2 = dispatch_rs2_tag;
      n.r1 = dispatch_rs1_rdy || dispatch_rs1_tag == 0;
      n.r2 = dispatch_rs2_rdy || dispatch_rs2_tag == 0;
      n.d1 = dispatch_rs1_rdy ? dispatch_rs1_data : 32'd0;
      n.d2 = dispatch_rs2_rdy ? dispatch_rs2_data : 32'd0;
      if (cdb_valid && !n.r1 && n.t1 == cdb_tag) begin n.r1 = 1; n.d1 = cdb_data; end
      if (cdb_valid && !n.r2 && n.t2 == cdb_tag) begin n.r2 = 1; n.d2 = cdb_data; end
      n.rob = dispatch_rob_id; n.pt = dispatch_pred_taken; n.ptgt = dispatch_pred_target;
      mq.push_back(n);
    end
    if (flush) mq.delete();
    @(posedge clk);
    #1;
    mres_v    = nres_v;
    mres_rob  = nres_v ? mex.rob : 5'd0;
    mres_mis  = nres_v && ((tk != mex.pt) || (tk && tg != mex.ptgt));
    mres_tgt  = nres_v ? (tk ? tg : mex.addr + 32'd4) : 32'd0;
    mres_link = nres_v ? mex.addr + 32'd4 : 32'd0;
    mex_v = nexv;
    mex   = nex;
    chk("res_valid", resolve_valid, mres_v);
    chk("res_rob", resolve_rob_id, mres_rob);
    chk("res_mis", resolve_mispredict, mres_mis);
    chk("res_target", resolve_target, mres_tgt);
    chk("res_link", resolve_link, mres_link);
  endtask

  initial begin
    logic [2:0] f3s [6];
    logic [6:0] ops [3];
    f3s = '{3'd0, 3'd1, 3'd4, 3'd5, 3'd6, 3'd7};
    ops = '{OP_BR, OP_JAL, OP_JALR};
    idle();
    disp(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    dispatch_valid = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_res_valid", resolve_valid, 0);
    chk("rst_ready", dispatch_ready, 1);
    chk("rst_bu_op", bu_opcode, 0);
    @(negedge clk);
    rst_n = 1;
    @(posedge clk);
    #1;

    // BEQ with equal ready operands, predicted not-taken
    disp(32'h1000, OP_BR, 3'd0, 12'h010, 6'd1, 1, 32'd5, 6'd2, 1, 32'd5, 5'd1, 0, 32'h0);
    tick(); idle(); tick(); tick();
    chk("t1_valid", resolve_valid, 1);
    chk("t1_mis", resolve_mispredict, 1);
    chk("t1_target", resolve_target, 32'h1010);
    tick();

    // BNE waiting on tag 7, woken two cycles after dispatch
    disp(32'h1100, OP_BR, 3'd1, 12'h040, 6'd7, 0, 32'd0, 6'd0, 0, 32'd0, 5'd2, 1, 32'h1140);
    tick(); idle(); tick();
    cdb(6'd7, 32'd3);
    tick(); idle(); tick(); tick();
    chk("t2_valid", resolve_valid, 1);
    chk("t2_rob", resolve_rob_id, 2);
    chk("t2_mis", resolve_mispredict, 0);
    tick();

    // fill the queue, wake only slot 2
    for (int i = 0; i < 4; i++) begin
      disp(32'h2000 + 32'(i * 16), OP_BR, 3'd0, 12'h008, 6'(i + 1), 0, 32'd0,
           6'd0, 0, 32'd0, 5'(4 + i), 0, 32'h0);
      tick();
    end
    idle();
    chk("t3_full", dispatch_ready, 0);
    disp(32'h2400, OP_BR, 3'd0, 12'h008, 6'd0, 1, 32'd0, 6'd0, 1, 32'd0, 5'd9, 0, 32'h0);
    tick(); idle();
    cdb(6'd3, 32'd0);
    tick(); idle(); tick();
    chk("t3_ready", dispatch_ready, 1);
    chk("t3_issue", bu_instruction_addr, 32'h2020);
    tick();
    chk("t3_rob", resolve_rob_id, 6);
    cdb(6'd1, 32'd1); tick();
    cdb(6'd2, 32'd0); tick();
    cdb(6'd4, 32'd0); tick();
    idle();
    repeat (5) tick();

    // two ready ops back to back
    disp(32'h3000, OP_JAL, 3'd0, 12'h100, 6'd0, 0, 32'd0, 6'd0, 0, 32'd0, 5'd10, 1, 32'h3100);
    tick();
    disp(32'h3004, OP_JAL, 3'd0, 12'h200, 6'd0, 0, 32'd0, 6'd0, 0, 32'd0, 5'd11, 0, 32'h0);
    tick(); idle(); tick();
    chk("t4_first_valid", resolve_valid, 1);
    chk("t4_first_rob", resolve_rob_id, 10);
    tick();
    chk("t4_second_valid", resolve_valid, 1);
    chk("t4_second_rob", resolve_rob_id, 11);
    tick();

    // flush with three waiting entries and one op in ex
    for (int i = 0; i < 3; i++) begin
      disp(32'h4000 + 32'(i * 4), OP_BR, 3'd0, 12'h010, 6'(5 + i), 0, 32'd0,
           6'd0, 0, 32'd0, 5'(12 + i), 0, 32'h0);
      tick();
    end
    disp(32'h4100, OP_JAL, 3'd0, 12'h010, 6'd0, 0, 32'd0, 6'd0, 0, 32'd0, 5'd15, 1, 32'h4110);
    tick(); idle(); tick();
    flush = 1;
    tick(); idle();
    chk("t5_no_resolve", resolve_valid, 0);
    chk("t5_empty", dispatch_ready, 1);
    cdb(6'd5, 32'd0); tick(); idle();
    repeat (3) tick();

    // JAL with correct prediction, then dispatch-cycle CDB bypass
    disp(32'h100, OP_JAL, 3'd0, 12'h020, 6'd0, 0, 32'd0, 6'd0, 0, 32'd0, 5'd16, 1, 32'h120);
    tick(); idle(); tick(); tick();
    chk("t6_valid", resolve_valid, 1);
    chk("t6_mis", resolve_mispredict, 0);
    chk("t6_link", resolve_link, 32'h104);
    disp(32'h300, OP_BR, 3'd0, 12'h008, 6'd9, 0, 32'd0, 6'd10, 1, 32'h55, 5'd17, 1, 32'h308);
    cdb(6'd9, 32'h55);
    tick(); idle(); tick(); tick();
    chk("t6b_valid", resolve_valid, 1);
    chk("t6b_rob", resolve_rob_id, 17);
    chk("t6b_mis", resolve_mispredict, 0);
    tick();

    // random traffic
    for (int c = 0; c < 500; c++) begin
      logic [6:0]  op;
      logic [31:0] a;
      logic [11:0] im;
      idle();
      op = ops[$urandom_range(0, 2)];
      a  = $urandom;
      im = 12'($urandom);
      if ($urandom_range(0, 1) == 1)
        disp(a, op, f3s[$urandom_range(0, 5)], im,
             6'($urandom_range(0, 7)), 1'($urandom), 32'($urandom_range(0, 3)),
             6'($urandom_range(0, 7)), 1'($urandom), 32'($urandom_range(0, 3)),
             5'($urandom), 1'($urandom),
             ($urandom_range(0, 1) == 1) ? a + {{20{im[11]}}, im} : 32'($urandom));
      if ($urandom_range(0, 9) < 4) cdb(6'($urandom_range(1, 7)), 32'($urandom_range(0, 3)));
      if ($urandom_range(0, 49) == 0) flush = 1;
      tick();
    end
    idle();
    repeat (4) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
